eth_payload_port: RTL and testbench



---
 rtl/eth_payload_port_if.sv | 33 +++
 rtl/eth_payload_port.sv | 193 +++++++++++++++++++
 tb/tb_eth_payload_port.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_payload_port_if.sv
// Signal bundle between eth_payload_port and its environment: MAC rx/tx
// streams, client byte read/write port and the rx drop counter.
interface eth_payload_port_if;
  logic [7:0] i_rx_data;
  logic       i_rx_valid;
  logic       i_rx_last;
  logic       i_rx_err;
  logic [7:0] o_rdata;
  logic       o_rready;
  logic       i_rreq;
  logic [7:0] i_wdata;
  logic       i_wvalid;
  logic       o_wready;
  logic [7:0] o_tx_data;
  logic       o_tx_valid;
  logic       o_tx_last;
  logic       i_tx_ready;
  logic [7:0] o_rx_drop_cnt;

  modport slave (
    input  i_rx_data, i_rx_valid, i_rx_last, i_rx_err, i_rreq,
           i_wdata, i_wvalid, i_tx_ready,
    output o_rdata, o_rready, o_wready, o_tx_data, o_tx_valid, o_tx_last,
           o_rx_drop_cnt
  );

  modport master (
    output i_rx_data, i_rx_valid, i_rx_last, i_rx_err, i_rreq,
           i_wdata, i_wvalid, i_tx_ready,
    input  o_rdata, o_rready, o_wready, o_tx_data, o_tx_valid, o_tx_last,
           o_rx_drop_cnt
  );
endinterface

// File: rtl/eth_payload_port.sv
// Ethernet payload port: committed-frame rx byte FIFO and idle-committed tx
// frame buffer. Define ETH_PAYLOAD_PAD_EN to pad short tx frames to 46 bytes.
module eth_payload_port #(
  parameter int RX_AW       = 11,
  parameter int TX_AW       = 11,
  parameter int TX_IDLE_GAP = 64
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  eth_payload_port_if.slave   bus
);
  localparam int RX_DEPTH = 1 << RX_AW;
  localparam int TX_DEPTH = 1 << TX_AW;
  localparam int IW       = (TX_AW + 1 > 7) ? TX_AW + 1 : 7;
  localparam int GW       = $clog2(TX_IDLE_GAP + 1);

  typedef logic [RX_AW:0] rx_ptr_t;
  localparam rx_ptr_t            RX_FULL  = rx_ptr_t'(RX_DEPTH);
  localparam logic [TX_AW:0]     TX_MAX   = (TX_AW + 1)'(TX_DEPTH);
  localparam logic [GW-1:0]      IDLE_MAX = GW'(TX_IDLE_GAP);
  localparam logic [GW-1:0]      IDLE_HIT = GW'(TX_IDLE_GAP - 1);

  // ---------------------------------------------------------------- rx path
  logic [7:0] rx_mem [RX_DEPTH];
  rx_ptr_t    rx_wp_q, rx_wp_d, rx_cp_q, rx_cp_d, rx_rp_q, rx_rp_d;
  logic       rx_drop_q, rx_drop_d;
  logic       rready_q, rready_d;
  logic [7:0] rdata_q, rdata_d;
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic       rx_full, rx_ovf, rx_wr, rx_bad, rx_pop;

  assign rx_full = (rx_wp_q - rx_rp_q) == RX_FULL;
  assign rx_ovf  = bus.i_rx_valid && rx_full;
  assign rx_wr   = bus.i_rx_valid && !rx_full && !rx_drop_q;
  assign rx_bad  = rx_drop_q || rx_full || bus.i_rx_err;
  assign rx_pop  = bus.i_rreq && rready_q;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    rx_wp_d    = rx_wp_q;
    rx_cp_d    = rx_cp_q;
    rx_rp_d    = rx_rp_q;
    rx_drop_d  = rx_drop_q;
    drop_cnt_d = drop_cnt_q;
    rdata_d    = '0;

    if (rx_wr) rx_wp_d = rx_wp_q + 1'b1;

    // A bad frame unwinds to the last commit point and is counted once, at its end.
    if (bus.i_rx_valid && bus.i_rx_last) begin
      rx_drop_d = 1'b0;
      if (rx_bad) begin
        rx_wp_d = rx_cp_q;
        if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 1'b1;
      end else begin
        rx_cp_d = rx_wp_q + 1'b1;
      end
    end else if (rx_ovf) begin
      rx_drop_d = 1'b1;
    end

    if (rx_pop) rx_rp_d = rx_rp_q + 1'b1;

    rready_d = (rx_rp_d != rx_cp_d);
    if (rready_d) begin
      if (rx_wr && (rx_wp_q == rx_rp_d)) rdata_d = bus.i_rx_data;
      else                               rdata_d = rx_mem[rx_rp_d[RX_AW-1:0]];
    end
  end

  // NOTE: buffer storage is deliberately not reset; pointers alone define its contents.
  always_ff @(posedge i_clk) begin
    if (rx_wr) rx_mem[rx_wp_q[RX_AW-1:0]] <= bus.i_rx_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rx_wp_q    <= '0;
      rx_cp_q    <= '0;
      rx_rp_q    <= '0;
      rx_drop_q  <= 1'b0;
      rready_q   <= 1'b0;
      rdata_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      rx_wp_q    <= rx_wp_d;
      rx_cp_q    <= rx_cp_d;
      rx_rp_q    <= rx_rp_d;
      rx_drop_q  <= rx_drop_d;
      rready_q   <= rready_d;
      rdata_q    <= rdata_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.o_rready      = rready_q;
  assign bus.o_rdata       = rdata_q;
  assign bus.o_rx_drop_cnt = drop_cnt_q;

  // ---------------------------------------------------------------- tx path
  typedef enum logic [1:0] {TX_FILL, TX_SEND, TX_PAD} tx_state_e;

  tx_state_e      tx_state_q;
  logic [7:0]     tx_mem [TX_DEPTH];
  logic [TX_AW:0] tx_count_q, tx_count_nx;
  logic [GW-1:0]  tx_idle_q;
  logic [IW-1:0]  tx_idx_q, tx_idx_nx, tx_len_q;
  logic           wready_q, tx_valid_q, tx_last_q;
  logic [7:0]     tx_data_q, tx_first, tx_next;
  logic           tx_wr, tx_commit, tx_accept, tx_in_frame;

  function automatic logic [IW-1:0] frame_len(input logic [TX_AW:0] cnt);
`ifdef ETH_PAYLOAD_PAD_EN
    localparam logic [IW-1:0] PAD_LEN = IW'(46);
    return (IW'(cnt) < PAD_LEN) ? PAD_LEN : IW'(cnt);
`else
    return IW'(cnt);
`endif
  endfunction

  assign tx_wr       = (tx_state_q == TX_FILL) && wready_q && bus.i_wvalid;
  assign tx_count_nx = tx_wr ? tx_count_q + 1'b1 : tx_count_q;
  assign tx_commit   = (tx_state_q == TX_FILL) &&
                       (tx_wr ? (tx_count_nx == TX_MAX)
                              : ((tx_count_q != '0) && (tx_idle_q >= IDLE_HIT)));
  // Byte 0 may be written on the very edge that commits a one-entry buffer.
  assign tx_first    = (tx_count_q == '0) ? bus.i_wdata : tx_mem[0];
  assign tx_accept   = tx_valid_q && bus.i_tx_ready;
  assign tx_idx_nx   = tx_idx_q + 1'b1;
  assign tx_in_frame = tx_idx_nx < IW'(tx_count_q);
  assign tx_next     = tx_in_frame ? tx_mem[tx_idx_nx[TX_AW-1:0]] : 8'h00;

  always_ff @(posedge i_clk) begin
    if (tx_wr) tx_mem[tx_count_q[TX_AW-1:0]] <= bus.i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      tx_state_q <= TX_FILL;
      tx_count_q <= '0;
      tx_idle_q  <= '0;
      tx_idx_q   <= '0;
      tx_len_q   <= '0;
      wready_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      unique case (tx_state_q)
        TX_FILL: begin
          tx_count_q <= tx_count_nx;
          if (tx_wr)                      tx_idle_q <= '0;
          else if (tx_idle_q != IDLE_MAX) tx_idle_q <= tx_idle_q + 1'b1;
          if (tx_commit) begin
            tx_state_q <= TX_SEND;
            wready_q   <= 1'b0;
            tx_valid_q <= 1'b1;
            tx_data_q  <= tx_first;
            tx_idx_q   <= '0;
            tx_len_q   <= frame_len(tx_count_nx);
            tx_last_q  <= (frame_len(tx_count_nx) == IW'(1));
          end else begin
            wready_q   <= 1'b1;
          end
        end
        TX_SEND, TX_PAD: begin
          if (tx_accept) begin
            if (tx_last_q) begin
              tx_state_q <= TX_FILL;
              tx_count_q <= '0;
              tx_idle_q  <= '0;
              wready_q   <= 1'b1;
              tx_valid_q <= 1'b0;
              tx_last_q  <= 1'b0;
              tx_data_q  <= '0;
            end else begin
              tx_state_q <= tx_in_frame ? TX_SEND : TX_PAD;
              tx_idx_q   <= tx_idx_nx;
              tx_data_q  <= tx_next;
              tx_last_q  <= (tx_idx_nx == tx_len_q - 1'b1);
            end
          end
        end
        default: tx_state_q <= TX_FILL;
      endcase
    end
  end

  assign bus.o_wready   = wready_q;
  assign bus.o_tx_valid = tx_valid_q;
  assign bus.o_tx_last  = tx_last_q;
  assign bus.o_tx_data  = tx_data_q;
endmodule

// File: tb/tb_eth_payload_port.sv
// Self-checking bench for eth_payload_port: scoreboard queues for rx and tx
// bytes, one task per scenario, honouring ETH_PAYLOAD_PAD_EN when defined.
module tb_eth_payload_port;
  localparam int RX_DEPTH = 2048;
  localparam int TX_DEPTH = 2048;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  eth_payload_port_if bus ();
  eth_payload_port dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [7:0] rx_exp_q [$];
  logic [7:0] tx_exp_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_rx_data  = '0;
    bus.i_rx_valid = 1'b0;
    bus.i_rx_last  = 1'b0;
    bus.i_rx_err   = 1'b0;
    bus.i_rreq     = 1'b0;
    bus.i_wdata    = '0;
    bus.i_wvalid   = 1'b0;
    bus.i_tx_ready = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    checks++;
    if (bus.o_rready !== 1'b0 || bus.o_tx_valid !== 1'b0 || bus.o_tx_last !== 1'b0 ||
        bus.o_wready !== 1'b0 || bus.o_rdata !== 8'h00 || bus.o_tx_data !== 8'h00 ||
        bus.o_rx_drop_cnt !== 8'h00) begin
      errors++;
      $display("FAIL %s: rready=%b tx_valid=%b tx_last=%b wready=%b rdata=%h tx_data=%h drop=%0d, want all 0",
               tag, bus.o_rready, bus.o_tx_valid, bus.o_tx_last, bus.o_wready, bus.o_rdata,
               bus.o_tx_data, bus.o_rx_drop_cnt);
    end
  endtask

  task automatic check_drop(input logic [7:0] want);
    checks++;
    if (bus.o_rx_drop_cnt !== want) begin
      errors++;
      $display("FAIL rx_drop_cnt: got %0d want %0d", bus.o_rx_drop_cnt, want);
    end
  endtask

  // Drive one rx frame starting from an empty committed buffer.
  task automatic send_rx(input int n, input logic [7:0] base, input bit err, input bit good);
    logic want;
    for (int i = 0; i < n; i++) begin
      bus.i_rx_valid = 1'b1;
      bus.i_rx_data  = base + 8'(i);
      bus.i_rx_last  = (i == n - 1);
      bus.i_rx_err   = err && (i == n - 1);
      if (good) rx_exp_q.push_back(bus.i_rx_data);
      tick();
      want = good && (i == n - 1);
      checks++;
      if (bus.o_rready !== want) begin
        errors++;
        $display("FAIL rx_rready_byte%0d: got %b want %b", i, bus.o_rready, want);
      end
    end
    bus.i_rx_valid = 1'b0;
    bus.i_rx_last  = 1'b0;
    bus.i_rx_err   = 1'b0;
  endtask

  task automatic read_rx(input int n);
    logic [7:0] want;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (bus.o_rready !== 1'b1) begin
        errors++;
        $display("FAIL rx_ready_pop%0d: got %b want 1", i, bus.o_rready);
      end
      if (rx_exp_q.size() == 0) begin
        errors++;
        $display("FAIL rx_scoreboard_empty: pop %0d has no expected byte", i);
      end else begin
        want = rx_exp_q.pop_front();
        checks++;
        if (bus.o_rdata !== want) begin
          errors++;
          $display("FAIL rx_data_pop%0d: got %h want %h", i, bus.o_rdata, want);
        end
      end
      bus.i_rreq = 1'b1;
      tick();
    end
    bus.i_rreq = 1'b0;
    checks++;
    if (bus.o_rready !== 1'b0) begin
      errors++;
      $display("FAIL rx_ready_after_drain: got %b want 0", bus.o_rready);
    end
  endtask

  // Write n client bytes; returns the number of bytes the MAC side should see.
  task automatic write_tx(input int n, input logic [7:0] base, output int total);
    for (int i = 0; i < n; i++) begin
      checks++;
      if (bus.o_wready !== 1'b1 || bus.o_tx_valid !== 1'b0) begin
        errors++;
        $display("FAIL tx_fill_byte%0d: wready=%b tx_valid=%b want 1/0", i, bus.o_wready, bus.o_tx_valid);
      end
      bus.i_wvalid = 1'b1;
      bus.i_wdata  = base + 8'(i);
      tx_exp_q.push_back(bus.i_wdata);
      tick();
    end
    bus.i_wvalid = 1'b0;
    total = n;
`ifdef ETH_PAYLOAD_PAD_EN
    for (int k = n; k < 46; k++) tx_exp_q.push_back(8'h00);
    if (n < 46) total = 46;
`endif
  endtask

  task automatic recv_tx(input int total, input int stall_at, input int stall_len);
    int got = 0;
    int stalled = 0;
    int cyc = 0;
    logic [7:0] want;
    while (got < total && cyc < total + stall_len + 500) begin
      bit stall;
      stall = (got == stall_at) && (stalled < stall_len);
      bus.i_tx_ready = !stall;
      if (stall) begin
        checks++;
        if (bus.o_tx_valid !== 1'b1 || tx_exp_q.size() == 0 || bus.o_tx_data !== tx_exp_q[0] ||
            bus.o_tx_last !== (got == total - 1)) begin
          errors++;
          $display("FAIL tx_stall_hold%0d: valid=%b data=%h last=%b", stalled, bus.o_tx_valid,
                   bus.o_tx_data, bus.o_tx_last);
        end
        stalled++;
      end else if (bus.o_tx_valid === 1'b1) begin
        checks++;
        if (bus.o_wready !== 1'b0) begin
          errors++;
          $display("FAIL tx_wready_in_send: got %b want 0 at byte %0d", bus.o_wready, got);
        end
        if (tx_exp_q.size() == 0) begin
          errors++;
          $display("FAIL tx_scoreboard_empty: extra byte %h at %0d", bus.o_tx_data, got);
        end else begin
          want = tx_exp_q.pop_front();
          checks++;
          if (bus.o_tx_data !== want || bus.o_tx_last !== (got == total - 1)) begin
            errors++;
            $display("FAIL tx_byte%0d: got %h last=%b want %h last=%b", got, bus.o_tx_data,
                     bus.o_tx_last, want, (got == total - 1));
          end
        end
        got++;
      end
      tick();
      cyc++;
    end
    bus.i_tx_ready = 1'b0;
    checks++;
    if (got != total) begin
      errors++;
      $display("FAIL tx_timeout: got %0d bytes want %0d", got, total);
    end
    checks++;
    if (bus.o_tx_valid !== 1'b0 || bus.o_wready !== 1'b1) begin
      errors++;
      $display("FAIL tx_frame_end: tx_valid=%b wready=%b want 0/1", bus.o_tx_valid, bus.o_wready);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (3) tick();
    check_outputs_zero("reset_state");
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.o_wready !== 1'b1 || bus.o_rready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: wready=%b rready=%b want 1/0", bus.o_wready, bus.o_rready);
    end
  endtask

  task automatic test_rx_good();
    send_rx(46, 8'h00, 1'b0, 1'b1);
    read_rx(46);
    check_drop(8'd0);
  endtask

  task automatic test_rx_err();
    send_rx(10, 8'h50, 1'b1, 1'b0);
    check_drop(8'd1);
    send_rx(46, 8'h80, 1'b0, 1'b1);
    read_rx(46);
  endtask

  task automatic test_rx_overflow();
    send_rx(RX_DEPTH + 2, 8'h11, 1'b0, 1'b0);
    check_drop(8'd2);
    send_rx(20, 8'hC0, 1'b0, 1'b1);
    read_rx(20);
  endtask

  task automatic test_tx_frame();
    int total;
    write_tx(46, 8'hA0, total);
    recv_tx(total, -1, 0);
  endtask

  task automatic test_tx_short();
    int total;
    write_tx(10, 8'h10, total);
    recv_tx(total, -1, 0);
  endtask

  task automatic test_tx_backpressure();
    int total;
    write_tx(46, 8'h30, total);
    recv_tx(total, 19, 5);
  endtask

  task automatic test_tx_full();
    int total;
    write_tx(TX_DEPTH, 8'h00, total);
    checks++;
    if (bus.o_tx_valid !== 1'b1 || bus.o_wready !== 1'b0) begin
      errors++;
      $display("FAIL tx_full_commit: tx_valid=%b wready=%b want 1/0", bus.o_tx_valid, bus.o_wready);
    end
    recv_tx(total, -1, 0);
  endtask

  task automatic test_reset_mid();
    int total;
    int cyc = 0;
    bit seen = 1'b0;
    logic [7:0] want;
    write_tx(46, 8'h60, total);
    while (bus.o_tx_valid !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    checks++;
    if (bus.o_tx_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_tx_start: tx_valid=%b want 1", bus.o_tx_valid);
    end
    for (int c = 0; c < 29; c++) begin
      bus.i_tx_ready = 1'b1;
      want = tx_exp_q.pop_front();
      checks++;
      if (bus.o_tx_data !== want) begin
        errors++;
        $display("FAIL mid_tx_byte%0d: got %h want %h", c, bus.o_tx_data, want);
      end
      bus.i_rx_valid = (c >= 17);
      bus.i_rx_data  = 8'(c - 17);
      tick();
    end
    bus.i_rx_valid = 1'b1;
    bus.i_rx_data  = 8'd12;
    rst_n = 1'b0;
    tick();
    check_outputs_zero("mid_reset_outputs");
    rst_n = 1'b1;
    bus.i_rx_valid = 1'b0;
    tick();
    checks++;
    if (bus.o_wready !== 1'b1 || bus.o_rready !== 1'b0 || bus.o_tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_release: wready=%b rready=%b tx_valid=%b want 1/0/0",
               bus.o_wready, bus.o_rready, bus.o_tx_valid);
    end
    tx_exp_q.delete();
    rx_exp_q.delete();
    repeat (100) begin
      if (bus.o_tx_valid !== 1'b0 || bus.o_rready !== 1'b0) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL mid_reset_residue: partial frame emitted after release");
    end
    bus.i_tx_ready = 1'b0;
    write_tx(3, 8'hE0, total);
    recv_tx(total, -1, 0);
  endtask

  initial begin
    test_reset();
    test_rx_good();
    test_rx_err();
    test_rx_overflow();
    test_tx_frame();
    test_tx_short();
    test_tx_backpressure();
    test_tx_full();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
